// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  // States in which the inter-byte timer runs.
  function automatic logic is_rx_wait(state_e s);
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Link/ALU-side signal bundle of the sequencer; master is the controller.
interface alu_seq_ctrl_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] rx_data;
  logic         rx_done;
  logic         tx_done;
  logic [N-1:0] alu_result;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [5:0]   alu_op;
  logic [N-1:0] tx_data;
  logic         tx_start;
  logic         busy;
  logic         timeout;
  logic         rx_drop;

  modport master (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, rx_drop
  );

  modport slave (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, rx_drop
  );
endinterface

// File: rtl/alu_seq_ctrl_byte_timer.sv
// Saturating inter-byte cycle counter; expired while the count sits at TIMEOUT-1.
module byte_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned   W    = $clog2(TIMEOUT);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Collects A, B and opcode bytes, drives the ALU, and hands the result to TX.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic            clk,
  input logic            reset,
  alu_seq_ctrl_if.master bus
);

  state_e       state_q, state_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [5:0]   alu_op_q, alu_op_d;
  logic [N-1:0] tx_data_q, tx_data_d;
  logic         tx_start_q, tx_start_d;
  logic         busy_q, busy_d;
  logic         timeout_q, timeout_d;
  logic         rx_drop_q, rx_drop_d;

  logic         tmr_clear, tmr_enable, tmr_expired;

  byte_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_byte_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Timer held clear outside the RX wait states, so entry always starts at 0.
  always_comb begin
    tmr_clear  = !is_rx_wait(state_q) || bus.rx_done;
    tmr_enable = is_rx_wait(state_q) && !bus.rx_done;
  end

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    rx_drop_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_done) begin
          alu_a_d = bus.rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (bus.rx_done) begin
          alu_b_d = bus.rx_data;
          state_d = ST_WAIT_OP;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        if (bus.rx_done) begin
          alu_op_d = bus.rx_data[5:0];
          state_d  = ST_EXEC;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Registering tx_start here lands the pulse in the SEND cycle.
        tx_data_d  = bus.alu_result;
        tx_start_d = 1'b1;
        rx_drop_d  = bus.rx_done;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        rx_drop_d = bus.rx_done;
        state_d   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        rx_drop_d = bus.rx_done;
        if (bus.tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;
  assign bus.rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU on the slave side.
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_tmo   = 0;
  int n_drop  = 0;

  alu_seq_ctrl_if #(.N(8)) bus ();

  alu_seq_ctrl #(
    .N       (8),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: shifts move operand A by one place.
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_NOR:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
      OP_SRA:  bus.alu_result = {bus.alu_a[7], bus.alu_a[7:1]};
      OP_SRL:  bus.alu_result = {1'b0, bus.alu_a[7:1]};
      default: bus.alu_result = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (bus.tx_start) n_start++;
    if (bus.timeout)  n_tmo++;
    if (bus.rx_drop)  n_drop++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  // Called right after the opcode byte edge; leaves the DUT in WAIT_TX.
  task automatic check_exec(input logic [5:0] exp_op, input logic [7:0] exp_res);
    int s0;
    s0 = n_start;
    check("exec_op", bus.alu_op, exp_op);
    check("exec_busy", bus.busy, 1);
    check("exec_nostart", bus.tx_start, 0);
    @(negedge clk);
    check("send_start", bus.tx_start, 1);
    check("send_data", bus.tx_data, exp_res);
    repeat (3) @(negedge clk);
    check("hold_data", bus.tx_data, exp_res);
    check("hold_busy", bus.busy, 1);
    check("start_once", n_start - s0, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [5:0] exp_op, input logic [7:0] exp_res);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check_exec(exp_op, exp_res);
  endtask

  task automatic finish_tx();
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("idle_after_tx", bus.busy, 0);
  endtask

  initial begin
    int t0, s0, d0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_a", bus.alu_a, 0);
    check("rst_op", bus.alu_op, 0);
    check("rst_txd", bus.tx_data, 0);
    check("rst_flags", {bus.tx_start, bus.busy, bus.timeout, bus.rx_drop}, 0);
    reset = 1'b0;

    run_op(8'h05, 8'h03, 8'h20, 6'b100000, 8'h08);
    // Back-to-back: A byte sampled on the edge right after WAIT_TX -> IDLE.
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    bus.rx_data = 8'h03;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    check("b2b_a", bus.alu_a, 8'h03);
    check("b2b_busy", bus.busy, 1);
    send_byte(8'h05);
    send_byte(8'h22);
    check_exec(6'b100010, 8'hFE);
    finish_tx();

    run_op(8'h80, 8'h00, 8'h03, 6'b000011, 8'hC0);
    finish_tx();
    run_op(8'h80, 8'h00, 8'h02, 6'b000010, 8'h40);
    finish_tx();
    run_op(8'hF0, 8'h3C, 8'h24, 6'b100100, 8'h30);
    finish_tx();
    run_op(8'hF0, 8'h3C, 8'h27, 6'b100111, 8'h03);
    finish_tx();
    run_op(8'h11, 8'h22, 8'h3F, 6'b111111, 8'h00);
    finish_tx();
    run_op(8'h05, 8'h03, 8'hE0, 6'b100000, 8'h08);
    finish_tx();

    // tx_done outside WAIT_TX is ignored.
    send_byte(8'h0A);
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("txdone_ignored", bus.busy, 1);
    send_byte(8'h01);
    send_byte(8'h26);
    check_exec(6'b100110, 8'h0B);
    finish_tx();

    // Timeout after 16 idle cycles in WAIT_B.
    t0 = n_tmo;
    send_byte(8'h07);
    repeat (15) @(negedge clk);
    check("tmo_not_yet", {bus.timeout, bus.busy}, 2'b01);
    @(negedge clk);
    check("tmo_pulse", {bus.timeout, bus.busy}, 2'b10);
    check("tmo_keep_a", bus.alu_a, 8'h07);
    @(negedge clk);
    check("tmo_once", n_tmo - t0, 1);
    run_op(8'h01, 8'h01, 8'h20, 6'b100000, 8'h02);
    finish_tx();

    // A byte arriving in the expiry cycle wins over the timeout.
    t0 = n_tmo;
    send_byte(8'h09);
    repeat (14) @(negedge clk);
    send_byte(8'h04);
    check("edge_accept_b", bus.alu_b, 8'h04);
    check("edge_busy", bus.busy, 1);
    send_byte(8'h22);
    check_exec(6'b100010, 8'h05);
    check("edge_no_tmo", n_tmo - t0, 0);
    finish_tx();

    // Bytes received in WAIT_TX are dropped.
    run_op(8'h02, 8'h03, 8'h20, 6'b100000, 8'h05);
    d0 = n_drop;
    send_byte(8'h55);
    check("drop_pulse", bus.rx_drop, 1);
    send_byte(8'h66);
    @(negedge clk);
    check("drop_count", n_drop - d0, 2);
    check("drop_txd", bus.tx_data, 8'h05);
    check("drop_a", bus.alu_a, 8'h02);
    check("drop_busy", bus.busy, 1);
    finish_tx();
    run_op(8'h0C, 8'h0A, 8'h25, 6'b100101, 8'h0E);
    finish_tx();

    // Asynchronous reset in WAIT_OP.
    send_byte(8'h44);
    send_byte(8'h11);
    #2 reset = 1'b1;
    #1;
    check("rst_wop_regs", {bus.alu_a, bus.alu_b, bus.tx_data}, 0);
    check("rst_wop_busy", bus.busy, 0);
    s0 = n_start;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_wop_nostart", n_start - s0, 0);

    // Asynchronous reset in WAIT_TX.
    run_op(8'h06, 8'h07, 8'h20, 6'b100000, 8'h0D);
    #2 reset = 1'b1;
    #1;
    check("rst_wtx_regs", {bus.alu_op, bus.tx_data, bus.alu_a}, 0);
    check("rst_wtx_flags", {bus.tx_start, bus.busy}, 0);
    s0 = n_start;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_wtx_nostart", n_start - s0, 0);
    check("rst_wtx_idle", bus.busy, 0);
    run_op(8'h10, 8'h20, 8'h20, 6'b100000, 8'h30);
    finish_tx();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
